// File: rtl/regwb_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regwb_ctrl_if : write-back request, memory read and reg-file bus     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface regwb_ctrl_if #(
    parameter int RA_W = 3
);
    logic            wb_valid;
    logic            wb_ready;
    logic            wb_src;
    logic            wb_byte;
    logic [RA_W-1:0] wb_rd;
    logic [15:0]     wb_addr;
    logic            mem_rd;
    logic [15:0]     mem_addr;
    logic            mem_ack;
    logic            mdr_ld;
    logic            byte_hi;
    logic            alu_mem;
    logic            d8_d16;
    logic            reg_we;
    logic [RA_W-1:0] reg_waddr;
    logic            bus_err;
    logic            busy;

    // Controller side
    modport slave (
        input  wb_valid, wb_src, wb_byte, wb_rd, wb_addr, mem_ack,
        output wb_ready, mem_rd, mem_addr, mdr_ld, byte_hi, alu_mem,
               d8_d16, reg_we, reg_waddr, bus_err, busy
    );

    // Decode / memory / register-file side
    modport master (
        output wb_valid, wb_src, wb_byte, wb_rd, wb_addr, mem_ack,
        input  wb_ready, mem_rd, mem_addr, mdr_ld, byte_hi, alu_mem,
               d8_d16, reg_we, reg_waddr, bus_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/regwb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regwb_ctrl : write-back controller (ALU / byte / word loads)         |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module regwb_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int RA_W    = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    regwb_ctrl_if.slave        bus
);
    localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_WRITE    = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_wait_cnt;
    logic [RA_W-1:0] r_rd;
    logic            r_byte;
    logic [15:0]     r_mem_addr;
    logic            r_byte_hi;
    logic            r_alu_mem;
    logic            r_d8_d16;
    logic [RA_W-1:0] r_reg_waddr;
    logic            r_bus_err;

    logic            w_alu_go;
    logic            w_load_go;
    logic            w_misalign;
    logic            w_ack_go;
    logic            w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_alu_go     = 1'b0;
        w_load_go    = 1'b0;
        w_misalign   = 1'b0;
        w_ack_go     = 1'b0;
        w_timeout    = 1'b0;
        bus.wb_ready = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.busy     = 1'b0;
        bus.reg_we   = 1'b0;
        bus.mdr_ld   = 1'b0;
        case (r_state)
            S_IDLE, S_WRITE: begin
                bus.wb_ready = 1'b1;
                bus.reg_we   = (r_state == S_WRITE);
                w_next       = S_IDLE;
                if (bus.wb_valid) begin
                    if (bus.wb_src) begin
                        w_alu_go = 1'b1;
                        w_next   = S_WRITE;
                    end else if (!bus.wb_byte && bus.wb_addr[0]) begin
                        w_misalign = 1'b1;
                        w_next     = S_IDLE;
                    end else begin
                        w_load_go = 1'b1;
                        w_next    = S_MEM_WAIT;
                    end
                end
            end
            S_MEM_WAIT: begin
                bus.mem_rd = 1'b1;
                bus.busy   = 1'b1;
                // Ack takes priority over the final timeout cycle
                if (bus.mem_ack) begin
                    w_ack_go   = 1'b1;
                    bus.mdr_ld = 1'b1;
                    w_next     = S_WRITE;
                end else if (r_wait_cnt == C_WAIT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt  <= 8'd0;
            r_rd        <= '0;
            r_byte      <= 1'b0;
            r_mem_addr  <= 16'd0;
            r_byte_hi   <= 1'b0;
            r_alu_mem   <= 1'b0;
            r_d8_d16    <= 1'b0;
            r_reg_waddr <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_load_go) begin
                r_mem_addr <= bus.wb_addr;
                r_rd       <= bus.wb_rd;
                r_byte     <= bus.wb_byte;
                r_wait_cnt <= 8'd0;
            end else if ((r_state == S_MEM_WAIT) && !bus.mem_ack && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            // Mux selects only change on entry to WRITE so they stay stable elsewhere
            if (w_alu_go) begin
                r_alu_mem   <= 1'b1;
                r_reg_waddr <= bus.wb_rd;
            end
            if (w_ack_go) begin
                r_alu_mem   <= 1'b0;
                r_reg_waddr <= r_rd;
                r_d8_d16    <= !r_byte;
                r_byte_hi   <= r_mem_addr[0];
            end
            r_bus_err <= w_misalign | w_timeout;
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.byte_hi   = r_byte_hi;
    assign bus.alu_mem   = r_alu_mem;
    assign bus.d8_d16    = r_d8_d16;
    assign bus.reg_waddr = r_reg_waddr;
    assign bus.bus_err   = r_bus_err;

endmodule
`default_nettype wire

// File: doc/regwb_ctrl.md
# regwb_ctrl

Register write-back controller for the 16-bit datapath. It accepts write-back requests from decode, runs the memory read handshake for loads, and drives the select lines of the write-data mux (ALU result, sign-extended byte, or 16-bit word). It also drives the register-file write strobe and address and flags bus errors (misaligned word loads, memory timeouts). It sits between decode/execute, the memory interface and the register file.

## Interface
- TIMEOUT, 15: maximum number of unacknowledged memory wait cycles before a bus error (range 1–255).
- RA_W, 3: register address width.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- wb_valid  in  1  write-back request valid.
- wb_ready  out  1  request accepted when wb_valid && wb_ready.
- wb_src  in  1  1 = ALU result, 0 = memory load.
- wb_byte  in  1  load size: 1 = byte (sign-extended), 0 = word.
- wb_rd  in  RA_W  destination register.
- wb_addr  in  16  load address (ignored for ALU requests).
- mem_rd  out  1  memory read request, held until ack or abort.
- mem_addr  out  16  registered load address.
- mem_ack  in  1  read data valid this cycle.
- mdr_ld  out  1  capture memory data into the MDR (same cycle as mem_ack).
- byte_hi  out  1  byte-lane select for 8-bit loads (registered wb_addr[0]).
- alu_mem  out  1  write-data mux select: 1 = ALU, 0 = memory path.
- d8_d16  out  1  memory-path select: 1 = 16-bit word, 0 = sign-extended byte.
- reg_we  out  1  register-file write strobe, one cycle.
- reg_waddr  out  RA_W  register-file write address.
- bus_err  out  1  one-cycle error pulse.
- busy  out  1  high in MEM_WAIT.

## Operation
- States: IDLE, MEM_WAIT, WRITE.
- wb_ready = 1 in IDLE and WRITE, 0 in MEM_WAIT. It is a function of state only.
- On accept with wb_src = 1:
  - next state WRITE.
  - In WRITE: reg_we = 1, alu_mem = 1, reg_waddr = registered wb_rd.
- On accept with wb_src = 0, wb_byte = 0, wb_addr[0] = 1 (misaligned word load):
  - next state IDLE, bus_err = 1 for one cycle.
  - No mem_rd and no register write.
- On accept of any other load:
  - next state MEM_WAIT; mem_addr, byte_hi, rd and size are registered.
  - In MEM_WAIT: mem_rd = 1, busy = 1.
- MEM_WAIT with mem_ack = 1:
  - mdr_ld = 1 in the same cycle; next state WRITE.
  - In WRITE: reg_we = 1, alu_mem = 0, d8_d16 = !byte.
- MEM_WAIT timeout:
  - A 8-bit wait counter clears on entry and increments on each cycle without ack.
  - At the TIMEOUT-th unacked cycle the next state is IDLE, with bus_err = 1 in that next cycle and no write.
- From WRITE:
  - A new accept goes to WRITE, IDLE or MEM_WAIT by the same rules. Back-to-back ALU write-backs sustain one per cycle.
  - Otherwise next state IDLE.
- alu_mem, d8_d16, reg_waddr and byte_hi are registered. They hold their last values outside WRITE.
- mem_ack outside MEM_WAIT is ignored.
- mem_ack on the TIMEOUT-th wait cycle: ack wins, with a normal write and no bus_err.
- Upstream holds aluout valid through the cycle after ALU-request acceptance. The MDR holds data from mdr_ld until the WRITE cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - state IDLE, wait counter 0.
  - All outputs 0: mem_rd, mem_addr, mdr_ld, byte_hi, alu_mem, d8_d16, reg_we, reg_waddr, bus_err, busy.
  - Exception: wb_ready = 1 (IDLE).
- Reset mid-load drops mem_rd immediately. The pending write is discarded.
- ALU latency: accept at cycle N → reg_we at N+1.
- Load latency: accept at N → mem_rd from N+1 → mem_ack at cycle M → reg_we at M+1. Minimum load latency is 2 cycles (ack at N+1).
- Misaligned word load: bus_err at N+1.
- Timeout: accept at N, no ack → bus_err at N+TIMEOUT+1. mem_rd is low from that cycle.
- reg_we, mdr_ld and bus_err are never high for more than one cycle per request.
- reg_we and bus_err are never high together.

## Test plan
- Reset, then ALU requests rd=3 at cycle 1 and rd=5 at cycle 2 → reg_we=1 with alu_mem=1 at cycles 2 and 3, reg_waddr=3 then 5, wb_ready stays 1.
- Word load, addr=0x0040, rd=2, mem_ack after 3 wait cycles → mem_rd high for 3 cycles, mem_addr=0x0040, mdr_ld with ack, next cycle reg_we=1, alu_mem=0, d8_d16=1, reg_waddr=2.
- Byte load, addr=0x0041, rd=7, immediate ack → byte_hi=1, reg_we one cycle after ack, d8_d16=0, alu_mem=0.
- Word load, addr=0x0013 → bus_err=1 next cycle, mem_rd never asserted, reg_we never asserted.
- TIMEOUT=4, load with no ack → mem_rd high for 4 cycles, bus_err at accept+5, no reg_we. Same setup with ack on the 4th wait cycle → reg_we and no bus_err.
- Assert rst_n low on the 2nd MEM_WAIT cycle → mem_rd falls asynchronously, no reg_we afterwards, wb_ready=1 after release.
